// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: forwarding, load-use/branch/cache-miss stalls and flushes,
// plus an optional one-entry multiply/divide scoreboard (enable with HZ_MULDIV_SCOREBOARD_EN).
module hazard_scoreboard #(
    parameter int unsigned AW        = 5,
    parameter int unsigned MD_LAT    = 4,
    parameter logic [1:0]  LOAD_CODE = 2'b01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] Rs1D,
    input  logic [AW-1:0] Rs2D,
    input  logic [AW-1:0] RdD,
    input  logic          RegWriteD,
    input  logic          MdStartD,
    input  logic [AW-1:0] Rs1E,
    input  logic [AW-1:0] Rs2E,
    input  logic [AW-1:0] RdE,
    input  logic          MdStartE,
    input  logic [1:0]    ResultSrcE,
    input  logic [1:0]    PCSrcE,
    input  logic [AW-1:0] RdM,
    input  logic [AW-1:0] RdW,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          ICacheStallF,
    input  logic          DCacheStallM,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushW,
    output logic          MdCommit,
    output logic [AW-1:0] MdRd,
    output logic          MdBusy
);

    localparam int unsigned CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rd_m, input logic wr_m,
                                           input logic [AW-1:0] rd_w, input logic wr_w);
        if (rs == '0)                 return 2'b00;
        else if (rs == rd_m && wr_m)  return 2'b10;
        else if (rs == rd_w && wr_w)  return 2'b01;
        else                          return 2'b00;
    endfunction

    logic          load_use;
    logic          md_hazard;
    logic          md_done;
    logic          md_active;
    logic [AW-1:0] md_rd_q;

    assign load_use = (ResultSrcE == LOAD_CODE) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HZ_MULDIV_SCOREBOARD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

    md_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [AW-1:0] md_rd_next;
    logic          launch;

    assign launch = MdStartE && !DCacheStallM;

    // State register: the counter keeps running through cache stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            md_rd_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_rd_q <= md_rd_next;
        end
    end

    // Next state: a launch is accepted when idle or in the commit cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_rd_next = md_rd_q;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (launch) begin
                    state_next = BUSY;
                    cnt_next   = CW'(MD_LAT - 1);
                    md_rd_next = RdE;
                end
            end
            BUSY: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign md_active = (state != IDLE);
    assign md_done   = (state == DONE);
    assign md_hazard = md_active &&
                       (MdStartD ||
                        ((md_rd_q != '0) && ((md_rd_q == Rs1D) || (md_rd_q == Rs2D))) ||
                        ((md_rd_q != '0) && RegWriteD && (RdD == md_rd_q)));
`else
    logic unused_md_inputs;

    assign unused_md_inputs = ^{clk, MdStartD, MdStartE, RegWriteD, RdD};
    assign md_active = 1'b0;
    assign md_done   = 1'b0;
    assign md_hazard = 1'b0;
    assign md_rd_q   = '0;
`endif

    // Output decode: priority stall/flush selection, all forced low during reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MdCommit  = 1'b0;
        MdRd      = '0;
        MdBusy    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            MdBusy    = md_active;
            MdCommit  = md_done;
            if (md_done) MdRd = md_rd_q;
            if (DCacheStallM) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE != 2'b00) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use || md_hazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (ICacheStallF) begin
                StallF = 1'b1;
                FlushD = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against a timestamp-based reference model;
// follows HZ_MULDIV_SCOREBOARD_EN to decide whether the scoreboard is expected to be active.
module tb_hazard_scoreboard;

    localparam int unsigned AW     = 5;
    localparam int unsigned MD_LAT = 4;
    localparam logic [1:0]  LOAD   = 2'b01;
`ifdef HZ_MULDIV_SCOREBOARD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, MdRd;
    logic          RegWriteD, MdStartD, MdStartE, RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE, PCSrcE, ForwardAE, ForwardBE;
    logic          ICacheStallF, DCacheStallM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic          MdCommit, MdBusy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference scoreboard: cycle index and the cycle in which the pending result commits.
    int            cyc;
    int            commit_cyc;
    logic [AW-1:0] ref_rd;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .LOAD_CODE(LOAD)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MdStartD(MdStartD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .MdStartE(MdStartE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ICacheStallF(ICacheStallF), .DCacheStallM(DCacheStallM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MdCommit(MdCommit), .MdRd(MdRd), .MdBusy(MdBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_reg();
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic drive_random();
        Rs1D         = rand_reg();
        Rs2D         = rand_reg();
        RdD          = rand_reg();
        Rs1E         = rand_reg();
        Rs2E         = rand_reg();
        RdE          = rand_reg();
        RdM          = rand_reg();
        RdW          = rand_reg();
        RegWriteD    = 1'($urandom_range(0, 1));
        RegWriteM    = 1'($urandom_range(0, 1));
        RegWriteW    = 1'($urandom_range(0, 1));
        MdStartD     = ($urandom_range(0, 9) == 0);
        MdStartE     = ($urandom_range(0, 5) == 0);
        ResultSrcE   = 2'($urandom_range(0, 3));
        PCSrcE       = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        ICacheStallF = ($urandom_range(0, 4) == 0);
        DCacheStallM = ($urandom_range(0, 7) == 0);
    endtask

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (rs == RdM && RegWriteM) return 2'b10;
        if (rs == RdW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_active();
        return MD_EN && (commit_cyc >= 0) && (cyc <= commit_cyc);
    endfunction

    function automatic bit ref_done();
        return MD_EN && (commit_cyc >= 0) && (cyc == commit_cyc);
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [6:0] exp_ctrl();
        bit lu, md;
        lu = (ResultSrcE == LOAD) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        md = ref_active() && (MdStartD ||
                              (ref_rd != 0 && (ref_rd == Rs1D || ref_rd == Rs2D)) ||
                              (ref_rd != 0 && RegWriteD && RdD == ref_rd));
        if (DCacheStallM)       return 7'b1111_001;
        if (PCSrcE != 2'b00)    return 7'b0000_110;
        if (lu || md)           return 7'b1100_010;
        if (ICacheStallF)       return 7'b1000_100;
        return 7'b0000_000;
    endfunction

    task automatic check_outputs();
        logic [6:0] ctrl;
        ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        if (rst) begin
            check("rst_fwd",  32'({ForwardAE, ForwardBE}), 32'd0);
            check("rst_ctrl", 32'(ctrl), 32'd0);
            check("rst_md",   32'({MdCommit, MdBusy, MdRd}), 32'd0);
        end else begin
            check("fwd_a",     32'(ForwardAE), 32'(exp_fwd(Rs1E)));
            check("fwd_b",     32'(ForwardBE), 32'(exp_fwd(Rs2E)));
            check("ctrl",      32'(ctrl), 32'(exp_ctrl()));
            check("md_busy",   32'(MdBusy), 32'(ref_active()));
            check("md_commit", 32'(MdCommit), 32'(ref_done()));
            if (ref_done()) check("md_rd", 32'(MdRd), 32'(ref_rd));
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            commit_cyc = -1;
            ref_rd     = '0;
        end else if (MD_EN && MdStartE && !DCacheStallM && (!ref_active() || ref_done())) begin
            commit_cyc = cyc + int'(MD_LAT);
            ref_rd     = RdE;
        end
        cyc++;
    endtask

    initial begin
        cyc        = 0;
        commit_cyc = -1;
        ref_rd     = '0;
        rst        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_random();
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
            drive_random();
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
            rst = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
